if_id_decode: RTL and testbench

- IF/ID pipeline register combined with instruction-field split and load-use hazard detection for the 5-stage MIPS pipeline.
- Captures the fetched instruction and its PC+4 each cycle.
- Presents the decoded fields: opcode, rs, rt, rd, shamt, funct, the raw 16-bit immediate and the 26-bit jump index. The immediate feeds the sign-extension unit; the other fields feed the register file and control.
- Generates the stall request back to fetch when the instruction in ID depends on a load in EX.

---
 rtl/mips_pkg.sv | 17 +
 rtl/hazard_detect.sv | 36 +++
 rtl/if_id_decode.sv | 78 +++++++
 tb/tb_if_id_decode.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode constants and field widths
package mips_pkg;

    localparam int REG_W = 5;
    localparam int OP_W  = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    // sll $0,$0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard detection for the ID stage
module hazard_detect
    import mips_pkg::*;
(
    input  logic             id_valid,
    input  logic [OP_W-1:0]  id_opcode,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_valid,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             flush,
    output logic             stall
);

    logic uses_rt;
    logic rs_hit;
    logic rt_hit;

    // rt is a source only for R-type, branches and stores; elsewhere it is a destination
    always_comb begin
        uses_rt = 1'b0;
        case (id_opcode)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: uses_rt = 1'b1;
            default:                         uses_rt = 1'b0;
        endcase
    end

    assign rs_hit = (ex_rt == id_rs);
    assign rt_hit = uses_rt && (ex_rt == id_rt);

    // A wrong-path instruction in ID must never hold up fetch
    assign stall = !flush && id_valid && ex_valid && ex_memread
                   && (ex_rt != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/if_id_decode.sv
// rtl/if_id_decode.sv - IF/ID pipeline register with field split and load-use stall
module if_id_decode
    import mips_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  NOP_WORD = mips_pkg::NOP_WORD,
    parameter int               SCNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [XLEN-1:0]   if_pc_plus4,
    input  logic [XLEN-1:0]   if_instr,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic              ex_memread,
    input  logic [REG_W-1:0]  ex_rt,
    output logic              stall,
    output logic              id_valid,
    output logic [XLEN-1:0]   id_pc_plus4,
    output logic [XLEN-1:0]   id_instr,
    output logic [OP_W-1:0]   id_opcode,
    output logic [REG_W-1:0]  id_rs,
    output logic [REG_W-1:0]  id_rt,
    output logic [REG_W-1:0]  id_rd,
    output logic [REG_W-1:0]  id_shamt,
    output logic [5:0]        id_funct,
    output logic [15:0]       id_immediate,
    output logic [25:0]       id_jindex,
    output logic [SCNT_W-1:0] stall_count
);

    assign id_opcode    = id_instr[31:26];
    assign id_rs        = id_instr[25:21];
    assign id_rt        = id_instr[20:16];
    assign id_rd        = id_instr[15:11];
    assign id_shamt     = id_instr[10:6];
    assign id_funct     = id_instr[5:0];
    assign id_immediate = id_instr[15:0];
    assign id_jindex    = id_instr[25:0];

    hazard_detect u_hazard_detect (
        .id_valid   (id_valid),
        .id_opcode  (id_opcode),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .ex_valid   (ex_valid),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .flush      (flush),
        .stall      (stall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid    <= 1'b0;
            id_instr    <= NOP_WORD;
            id_pc_plus4 <= '0;
        end else if (flush) begin
            id_valid    <= 1'b0;
            id_instr    <= NOP_WORD;
            id_pc_plus4 <= '0;
        end else if (!stall) begin
            id_valid    <= if_valid;
            id_instr    <= if_valid ? if_instr : NOP_WORD;
            id_pc_plus4 <= if_pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {SCNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_if_id_decode.sv
// tb/tb_if_id_decode.sv - scoreboard bench for if_id_decode
module tb_if_id_decode;

    localparam int SCNT_W = 2;
    localparam int CMAX   = (1 << SCNT_W) - 1;

    logic              clk;
    logic              reset;
    logic              if_valid;
    logic [31:0]       if_pc_plus4;
    logic [31:0]       if_instr;
    logic              flush;
    logic              ex_valid;
    logic              ex_memread;
    logic [4:0]        ex_rt;
    logic              stall;
    logic              id_valid;
    logic [31:0]       id_pc_plus4;
    logic [31:0]       id_instr;
    logic [5:0]        id_opcode;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic [4:0]        id_shamt;
    logic [5:0]        id_funct;
    logic [15:0]       id_immediate;
    logic [25:0]       id_jindex;
    logic [SCNT_W-1:0] stall_count;

    if_id_decode #(.XLEN(32), .NOP_WORD(32'h0), .SCNT_W(SCNT_W)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc_plus4(if_pc_plus4),
        .if_instr(if_instr), .flush(flush), .ex_valid(ex_valid), .ex_memread(ex_memread),
        .ex_rt(ex_rt), .stall(stall), .id_valid(id_valid), .id_pc_plus4(id_pc_plus4),
        .id_instr(id_instr), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_shamt(id_shamt), .id_funct(id_funct),
        .id_immediate(id_immediate), .id_jindex(id_jindex), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          stall;
        bit          valid;
        logic [31:0] instr;
        logic [31:0] pc;
        int          count;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference state: what ID should hold, tracked as plain values
    bit          m_valid = 0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_pc    = 32'h0;
    int          m_count = 0;

    function automatic bit reads_rt(input logic [31:0] ins);
        int op;
        op = int'(ins >> 26);
        return (op == 'h00) || (op == 'h04) || (op == 'h05) || (op == 'h2B);
    endfunction

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    task automatic cycle(input string nm, input bit rst, input bit ifv, input logic [31:0] pc,
                         input logic [31:0] ins, input bit fl, input bit exv, input bit exmr,
                         input logic [4:0] exrt);
        exp_t e;
        int   rs, rt;
        bit   hz;
        @(negedge clk);
        reset = rst; if_valid = ifv; if_pc_plus4 = pc; if_instr = ins;
        flush = fl; ex_valid = exv; ex_memread = exmr; ex_rt = exrt;
        rs = int'((m_instr >> 21) & 32'h1F);
        rt = int'((m_instr >> 16) & 32'h1F);
        hz = m_valid && exv && exmr && (exrt != 0) &&
             ((int'(exrt) == rs) || (reads_rt(m_instr) && int'(exrt) == rt)) && !fl;
        e.name  = nm;
        e.stall = hz;
        if (rst) begin
            m_valid = 0; m_instr = 0; m_pc = 0; m_count = 0;
        end else begin
            if (hz && m_count < CMAX) m_count++;
            if (fl) begin
                m_valid = 0; m_instr = 0; m_pc = 0;
            end else if (!hz) begin
                m_valid = ifv; m_instr = ifv ? ins : 32'h0; m_pc = pc;
            end
        end
        e.valid = m_valid; e.instr = m_instr; e.pc = m_pc; e.count = m_count;
        q.push_back(e);
    endtask

    // Monitor: combinational stall mid-cycle, registered state just after the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, "stall", {31'b0, stall}, {31'b0, e.stall});
                @(posedge clk);
                #1;
                chk(e.name, "id_valid", {31'b0, id_valid}, {31'b0, e.valid});
                chk(e.name, "id_instr", id_instr, e.instr);
                chk(e.name, "id_pc_plus4", id_pc_plus4, e.pc);
                chk(e.name, "stall_count", {30'b0, stall_count}, e.count);
                chk(e.name, "id_opcode", {26'b0, id_opcode}, e.instr / 32'h0400_0000);
                chk(e.name, "id_rs", {27'b0, id_rs}, (e.instr / 32'h0020_0000) % 32);
                chk(e.name, "id_rt", {27'b0, id_rt}, (e.instr / 32'h0001_0000) % 32);
                chk(e.name, "id_rd", {27'b0, id_rd}, (e.instr / 32'h800) % 32);
                chk(e.name, "id_shamt", {27'b0, id_shamt}, (e.instr / 64) % 32);
                chk(e.name, "id_funct", {26'b0, id_funct}, e.instr % 64);
                chk(e.name, "id_immediate", {16'b0, id_immediate}, e.instr % 32'h1_0000);
                chk(e.name, "id_jindex", {6'b0, id_jindex}, e.instr % 32'h0400_0000);
            end
        end
    end

    localparam logic [31:0] ADDI8  = 32'h2108_0004;
    localparam logic [31:0] ADD10  = 32'h012B_5020;
    localparam logic [31:0] SW9    = 32'hAC89_0000;
    localparam logic [31:0] ADDI9  = 32'h2089_0001;
    localparam logic [31:0] ADD1R0 = 32'h0000_0820;

    initial begin
        int ops[7];
        logic [31:0] ins;
        reset = 1'b1; if_valid = 1'b0; if_pc_plus4 = '0; if_instr = '0;
        flush = 1'b0; ex_valid = 1'b0; ex_memread = 1'b0; ex_rt = '0;

        cycle("reset0", 1, 0, 0, 0, 0, 0, 0, 0);
        cycle("reset1", 1, 0, 0, 0, 0, 0, 0, 0);
        cycle("load_addi", 0, 1, 32'h404, ADDI8, 0, 0, 0, 0);
        cycle("load_add", 0, 1, 32'h408, ADD10, 0, 0, 0, 0);
        cycle("rs_hazard", 0, 1, 32'h40C, SW9, 0, 1, 1, 9);
        cycle("after_stall", 0, 1, 32'h40C, SW9, 0, 0, 0, 0);
        cycle("rt_hazard_sw", 0, 1, 32'h410, ADDI9, 0, 1, 1, 9);
        cycle("load_addi9", 0, 1, 32'h410, ADDI9, 0, 0, 0, 0);
        cycle("rt_nonuse", 0, 1, 32'h414, ADD1R0, 0, 1, 1, 9);
        cycle("rt_zero", 0, 1, 32'h418, ADD10, 0, 1, 1, 0);
        cycle("nonload", 0, 1, 32'h41C, ADD10, 0, 1, 0, 9);
        cycle("flush_vs_stall", 0, 1, 32'h420, ADDI8, 1, 1, 1, 9);
        cycle("invalid_fetch", 0, 0, 32'h424, 32'hDEAD_BEEF, 0, 0, 0, 0);
        cycle("reload_add", 0, 1, 32'h428, ADD10, 0, 0, 0, 0);
        cycle("reset_in_stall", 1, 1, 32'h42C, ADDI8, 0, 1, 1, 11);
        cycle("sat_load", 0, 1, 32'h430, ADD10, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            cycle($sformatf("saturate%0d", i), 0, 1, 32'h434, ADDI8, 0, 1, 1, 9);
        cycle("sat_reset", 1, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            ops[0] = 'h00; ops[1] = 'h04; ops[2] = 'h05; ops[3] = 'h2B;
            ops[4] = 'h23; ops[5] = 'h08; ops[6] = int'($urandom_range(63));
            ins = {ops[$urandom_range(6)][5:0], 5'($urandom_range(3)), 5'($urandom_range(3)),
                   16'($urandom)};
            cycle($sformatf("rand%0d", i), ($urandom_range(99) < 3), ($urandom_range(9) < 8),
                  $urandom, ins, ($urandom_range(9) == 0), ($urandom_range(9) < 7),
                  ($urandom_range(9) < 7), 5'($urandom_range(3)));
        end

        repeat (3) @(posedge clk);
        #2;
        chk("drain", "pending", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
